alu_arbiter: RTL
================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests (A, B, 4-bit op) from two independent masters over valid/ready handshakes, and grants the ALU round-robin. It drives the combinational ALU with the granted operands, registers the result, and returns it with the requester ID over a valid/ready response channel with backpressure. It sits between the datapath masters and the single ALU instance, so the ALU needs no duplication.

## Interface
- No parameters. Data width is fixed at 8 bits and op width at 4 bits.
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  8  requester 0 operands
- req0_op  in  4  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a, alu_b  out  8  operands driven to the shared ALU
- alu_op  out  4  opcode driven to the shared ALU
- alu_out  in  8  combinational ALU result
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  8  registered result
- rsp_id  out  1  requester that issued the result
- rsp_err  out  1  opcode was outside 4'b0000–4'b1000

## Operation
- ALU op encoding, which the bench model must match:
  - 0 = A+B; 1 = A−B; 2 = A&B; 3 = ~A; 4 = ~B
  - 5 = ~(A|B); 6 = A|B; 7 = A^B; 8 = ~(A&B)
  - 9–15 yield 8'h00
  - Arithmetic is modulo 256, with no carry or borrow output.
- State machine has two states:
  - IDLE: response register empty.
  - FULL: response register holds an unconsumed result.
- can_accept = (state==IDLE) | (state==FULL & rsp_ready).
- Grant rules:
  - Grant is evaluated only when can_accept is high.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - reqN_ready = can_accept & grant==N. It is combinational and may depend on reqN_valid of both ports.
- ALU drive:
  - alu_a/alu_b/alu_op = operands of the granted requester.
  - When no grant, they are driven from requester 0's inputs (don't-care, but stable).
- On acceptance, at the clock edge:
  - rsp_data <= alu_out; rsp_id <= N; rsp_err <= (op > 4'b1000).
  - rsp_valid <= 1; last_grant <= N; state -> FULL.
- FULL & rsp_ready & no new acceptance: rsp_valid <= 0, state -> IDLE.
- FULL & rsp_ready & new acceptance: response register reloads in the same edge and state stays FULL. This gives back-to-back throughput of one op per cycle.
- FULL & !rsp_ready:
  - rsp_data, rsp_id and rsp_err are held stable.
  - Both reqN_ready are 0.
- Requesters must hold operands stable while valid and not ready. The block does not re-check them after acceptance.

## Timing
- Reset values (synchronous, applied at the edge where rst=1):
  - state=IDLE; rsp_valid=0; rsp_data=8'h00; rsp_id=0; rsp_err=0.
  - last_grant=1, so requester 0 wins the first contention.
- reqN_ready is 0 in any cycle where rst=1.
- Latency: request accepted at edge k → rsp_valid=1 with result visible after edge k.
- Reset during FULL: the pending result is discarded. rsp_valid=0 in the cycle after the reset edge and no response is emitted.
- No combinational path from rsp_ready to rsp_data.
- A path exists from rsp_ready to reqN_ready; this is permitted.

## Test plan
- Basic op: req0 {A=8'h0F, B=8'h01, op=0} with rsp_ready=1.
  - Required: req0_ready=1 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_data=8'h10, rsp_id=0, rsp_err=0.
- Wrap-around: req1 {A=8'h00, B=8'h01, op=1} → rsp_data=8'hFF, rsp_id=1.
  - Also: req1 {A=8'hFF, B=8'h01, op=0} → rsp_data=8'h00.
- Contention: both requesters valid continuously with rsp_ready=1 after reset.
  - Required grant order: 0, 1, 0, 1.
  - One response per cycle with alternating rsp_id; req0 {8'hAA, 8'h0F, op=2} returns 8'h0A.
- Backpressure: rsp_ready=0 for 3 cycles while both requesters are valid.
  - Required: rsp_data/rsp_id held stable and req0_ready=req1_ready=0 throughout.
  - When rsp_ready rises, the next grant is accepted in that same cycle.
- Invalid op: req0 {A=8'h55, B=8'h33, op=4'b1001} → rsp_data=8'h00, rsp_err=1.
  - Follow-up op=8 on the same operands → rsp_data=8'hEE, rsp_err=0.
- Reset mid-operation: assert rst for 1 cycle while FULL with rsp_ready=0.
  - Required: rsp_valid=0 after the edge and no stale response.
  - With both requesters then valid, requester 0 is granted first.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between the two ALU requesters, the shared ALU and the response consumer.
// The arbiter uses the slave modport; the environment around it uses the master modport.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic [3:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic [3:0] req1_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_op;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id;
  logic       rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out,
    output rsp_valid, rsp_data, rsp_id, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out,
    input  rsp_valid, rsp_data, rsp_id, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational 8-bit ALU between two requesters
// and returns each registered result, tagged with its requester, over a backpressured channel.
module alu_arbiter (
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   bus
);

  typedef enum logic {
    IDLE,
    FULL
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       can_accept;
  logic       grant_valid;
  logic       grant_id;
  logic [7:0] rsp_data_q;
  logic       rsp_id_q;
  logic       rsp_err_q;

  // State and response register; a reload while FULL and drained gives one op per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_data_q <= 8'h00;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (grant_valid) begin
        rsp_data_q <= bus.alu_out;
        rsp_id_q   <= grant_id;
        rsp_err_q  <= (bus.alu_op > 4'b1000);
        last_grant <= grant_id;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_valid) state_next = FULL;
      end
      FULL: begin
        if (grant_valid)        state_next = FULL;
        else if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant only when the response slot is free or being drained this cycle
  always_comb begin
    can_accept  = !rst && ((state == IDLE) || bus.rsp_ready);
    grant_valid = can_accept && (bus.req0_valid || bus.req1_valid);
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
    else                                  grant_id = bus.req1_valid;

    bus.req0_ready = grant_valid && !grant_id;
    bus.req1_ready = grant_valid && grant_id;

    if (grant_valid && grant_id) begin
      bus.alu_a  = bus.req1_a;
      bus.alu_b  = bus.req1_b;
      bus.alu_op = bus.req1_op;
    end else begin
      bus.alu_a  = bus.req0_a;
      bus.alu_b  = bus.req0_b;
      bus.alu_op = bus.req0_op;
    end

    bus.rsp_valid = (state == FULL);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_id    = rsp_id_q;
    bus.rsp_err   = rsp_err_q;
  end

endmodule
